// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline types, memory-stage state encoding and bubble constants
package mem_stage_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    // A bubble only needs to kill the writeback controls; data fields are held.
    localparam logic BUBBLE_REG_WRITE = 1'b0;
    localparam logic BUBBLE_VAL2REG   = 1'b0;

    function automatic logic is_misaligned(input word_t addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb.sv
// rtl/mem_stage_mem_wb.sv - MEM/WB pipeline register built from dff/dff_16 cells
module dff (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= 1'b0;
        else if (en)
            q <= d;
    end
endmodule

module dff_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= 16'h0000;
        else if (en)
            q <= d;
    end
endmodule

module mem_wb
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      bubble,
    input  word_t     mem_data,
    input  word_t     alu_result,
    input  reg_addr_t dest,
    input  logic      val2reg,
    input  logic      reg_write,
    input  logic      halt,
    output word_t     wb_mem_data,
    output word_t     wb_alu_result,
    output reg_addr_t wb_dest,
    output logic      wb_val2reg,
    output logic      wb_reg_write,
    output logic      wb_halt
);
    logic load;
    assign load = ~bubble;

    dff_16 u_mem_data   (.clk(clk), .rst(rst), .en(load), .d(mem_data),   .q(wb_mem_data));
    dff_16 u_alu_result (.clk(clk), .rst(rst), .en(load), .d(alu_result), .q(wb_alu_result));

    for (genvar g = 0; g < 3; g++) begin : g_dest
        dff u_dest (.clk(clk), .rst(rst), .en(load), .d(dest[g]), .q(wb_dest[g]));
    end

    // Controls load every cycle so a bubble actively clears them; halt is held through bubbles.
    dff u_val2reg   (.clk(clk), .rst(rst), .en(1'b1),
                     .d(bubble ? BUBBLE_VAL2REG : val2reg),     .q(wb_val2reg));
    dff u_reg_write (.clk(clk), .rst(rst), .en(1'b1),
                     .d(bubble ? BUBBLE_REG_WRITE : reg_write), .q(wb_reg_write));
    dff u_halt      (.clk(clk), .rst(rst), .en(load), .d(halt), .q(wb_halt));
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: data-memory handshake FSM, stall generation and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst,
    input  word_t     RtIn,
    input  word_t     ALUoutIn,
    input  reg_addr_t WriteRegAddrIn,
    input  logic      MemEnableIn,
    input  logic      MemWrIn,
    input  logic      HaltIn,
    input  logic      Val2RegIn,
    input  logic      RegWriteIn,
    output logic      dmem_req,
    output logic      dmem_wr,
    output word_t     dmem_addr,
    output word_t     dmem_wdata,
    input  logic      dmem_ready,
    input  word_t     dmem_rdata,
    output logic      StallOut,
    output word_t     MemDataOut,
    output word_t     ALUoutOut,
    output reg_addr_t WriteRegAddrOut,
    output logic      Val2RegOut,
    output logic      RegWriteOut,
    output logic      HaltOut,
    output logic      ErrOut
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t    state, state_next;
    logic [7:0] wait_cnt;
    word_t     addr_q, wdata_q;
    logic      wr_q;
    reg_addr_t hold_dest;
    logic      hold_val2reg, hold_reg_write, hold_halt;
    logic      err_q;

    logic      capture, cnt_inc, err_set, bubble;
    word_t     wb_mem_data, wb_alu_result;
    reg_addr_t wb_dest;
    logic      wb_val2reg, wb_reg_write, wb_halt;

    // Request comes straight from the state so an asynchronous reset drops it at once.
    assign dmem_req   = (state == ST_BUSY);
    assign dmem_wr    = wr_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign ErrOut     = err_q;

    always_comb begin
        state_next    = state;
        StallOut      = 1'b0;
        capture       = 1'b0;
        cnt_inc       = 1'b0;
        err_set       = 1'b0;
        bubble        = 1'b1;
        wb_mem_data   = 16'h0000;
        wb_alu_result = ALUoutIn;
        wb_dest       = WriteRegAddrIn;
        wb_val2reg    = Val2RegIn;
        wb_reg_write  = RegWriteIn;
        wb_halt       = HaltIn;
        unique case (state)
            ST_IDLE: begin
                if (!MemEnableIn) begin
                    bubble = 1'b0;
                    if (HaltIn)
                        state_next = ST_HALTED;
                end else if (is_misaligned(ALUoutIn)) begin
                    StallOut   = 1'b1;
                    err_set    = 1'b1;
                    state_next = ST_HALTED;
                end else begin
                    StallOut   = 1'b1;
                    capture    = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dmem_ready) begin
                    bubble        = 1'b0;
                    wb_mem_data   = wr_q ? 16'h0000 : dmem_rdata;
                    wb_alu_result = addr_q;
                    wb_dest       = hold_dest;
                    wb_val2reg    = hold_val2reg;
                    wb_reg_write  = hold_reg_write;
                    wb_halt       = hold_halt;
                    state_next    = hold_halt ? ST_HALTED : ST_IDLE;
                end else begin
                    StallOut = 1'b1;
                    cnt_inc  = 1'b1;
                    if (wait_cnt == TIMEOUT_LAST) begin
                        err_set    = 1'b1;
                        state_next = ST_HALTED;
                    end
                end
            end
            ST_HALTED: StallOut = 1'b1;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= 8'd0;
            addr_q         <= 16'h0000;
            wdata_q        <= 16'h0000;
            wr_q           <= 1'b0;
            hold_dest      <= 3'd0;
            hold_val2reg   <= 1'b0;
            hold_reg_write <= 1'b0;
            hold_halt      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q         <= ALUoutIn;
                wdata_q        <= RtIn;
                wr_q           <= MemWrIn;
                hold_dest      <= WriteRegAddrIn;
                hold_val2reg   <= Val2RegIn;
                hold_reg_write <= RegWriteIn;
                hold_halt      <= HaltIn;
                wait_cnt       <= 8'd0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (err_set)
                err_q <= 1'b1;
        end
    end

    mem_wb u_mem_wb (
        .clk           (clk),
        .rst           (rst),
        .bubble        (bubble),
        .mem_data      (wb_mem_data),
        .alu_result    (wb_alu_result),
        .dest          (wb_dest),
        .val2reg       (wb_val2reg),
        .reg_write     (wb_reg_write),
        .halt          (wb_halt),
        .wb_mem_data   (MemDataOut),
        .wb_alu_result (ALUoutOut),
        .wb_dest       (WriteRegAddrOut),
        .wb_val2reg    (Val2RegOut),
        .wb_reg_write  (RegWriteOut),
        .wb_halt       (HaltOut)
    );
endmodule
